// File: rtl/pid_regbank_pkg.sv
// Shared constants for the PID register bank: address field widths,
// per-channel register indices, CTRL bit positions and index decode helpers.
package pid_regbank_pkg;

    localparam int unsigned CH_W    = 4;            // channel field, addr[7:4]
    localparam int unsigned IDX_W   = 4;            // register index field, addr[3:0]
    localparam int unsigned FIELD_W = CH_W + IDX_W; // decoded address bits
    localparam int unsigned NUM_SHADOW = 4;         // P, I, D, SP

    localparam logic [IDX_W-1:0] REG_P     = 4'd0;
    localparam logic [IDX_W-1:0] REG_I     = 4'd1;
    localparam logic [IDX_W-1:0] REG_D     = 4'd2;
    localparam logic [IDX_W-1:0] REG_SP    = 4'd3;
    localparam logic [IDX_W-1:0] REG_CTRL  = 4'd4;
    localparam logic [IDX_W-1:0] REG_PID_O = 4'd14;
    localparam logic [IDX_W-1:0] REG_PWM_O = 4'd15;

    localparam int unsigned CTRL_EN_BIT     = 0;    // stored enable
    localparam int unsigned CTRL_COMMIT_BIT = 1;    // write-only commit request

    // Writable registers: the four shadow gains plus CTRL.
    function automatic logic is_wr_reg(input logic [IDX_W-1:0] idx);
        return idx <= REG_CTRL;
    endfunction

    // Readable registers: writable ones plus the two status words.
    function automatic logic is_rd_reg(input logic [IDX_W-1:0] idx);
        return (idx <= REG_CTRL) || (idx == REG_PID_O) || (idx == REG_PWM_O);
    endfunction

endpackage

// File: rtl/pid_regbank_if.sv
// Register-bus interface for pid_regbank: a write port and a read port
// with one-cycle registered read data.
//   master: drives wr_en/wr_addr/wr_data/rd_en/rd_addr, receives rd_data/rd_valid
//   slave : the register bank side
interface pid_regbank_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/pid_chan_regs.sv
// One PID channel: shadow gain/setpoint registers, the active copy seen by
// the control loop, CTRL (enable + commit pending), and the sampled status
// words. The shadow set is copied to the active set on the channel's
// update_tick once a commit has been requested.
// Ports:
//   clk_in, reset          clock, synchronous active-high reset
//   wr_en/wr_idx/wr_data   already-decoded write for this channel
//   update_tick            loop sample strobe (commit point)
//   pid_i, pwm_i           status inputs, sampled every cycle
//   rd_idx, rd_word_c      combinational read of the indexed register
//   p_o/i_o/d_o/sp_o       active set
//   ch_enable, commit_done CTRL enable, one-cycle commit pulse
module pid_chan_regs
    import pid_regbank_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              update_tick,
    input  logic [DATA_W-1:0] pid_i,
    input  logic [DATA_W-1:0] pwm_i,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_word_c,
    output logic [DATA_W-1:0] p_o,
    output logic [DATA_W-1:0] i_o,
    output logic [DATA_W-1:0] d_o,
    output logic [DATA_W-1:0] sp_o,
    output logic              ch_enable,
    output logic              commit_done
);

    logic [DATA_W-1:0] shadow [NUM_SHADOW];
    logic [DATA_W-1:0] active [NUM_SHADOW];
    logic [DATA_W-1:0] pid_status;
    logic [DATA_W-1:0] pwm_status;
    logic              pending;
    logic              enable;
    logic              done;
    logic              commit_c;

    assign commit_c = pending && update_tick;

    // Register state. The commit copies the shadow values as they stood
    // before this edge, so a same-cycle shadow write lands in shadow only.
    // A CTRL write is applied after the commit, so a commit request made on
    // a tick cycle stays pending for a later tick.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_SHADOW; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
            pid_status <= '0;
            pwm_status <= '0;
            pending    <= 1'b0;
            enable     <= 1'b0;
            done       <= 1'b0;
        end else begin
            pid_status <= pid_i;
            pwm_status <= pwm_i;
            done       <= commit_c;

            if (commit_c) begin
                for (int unsigned k = 0; k < NUM_SHADOW; k++) begin
                    active[k] <= shadow[k];
                end
                pending <= 1'b0;
            end

            if (wr_en) begin
                if (wr_idx < REG_CTRL) begin
                    shadow[wr_idx[1:0]] <= wr_data;
                end else if (wr_idx == REG_CTRL) begin
                    enable <= wr_data[CTRL_EN_BIT];
                    if (wr_data[CTRL_COMMIT_BIT]) begin
                        pending <= 1'b1;
                    end
                end
            end
        end
    end

    // Read mux for this channel; unmapped indices read as zero.
    always_comb begin
        rd_word_c = '0;
        case (rd_idx)
            REG_P, REG_I, REG_D, REG_SP: rd_word_c = shadow[rd_idx[1:0]];
            REG_CTRL:                    rd_word_c = DATA_W'({pending, enable});
            REG_PID_O:                   rd_word_c = pid_status;
            REG_PWM_O:                   rd_word_c = pwm_status;
            default:                     rd_word_c = '0;
        endcase
    end

    assign p_o         = active[0];
    assign i_o         = active[1];
    assign d_o         = active[2];
    assign sp_o        = active[3];
    assign ch_enable   = enable;
    assign commit_done = done;

endmodule

// File: rtl/pid_regbank.sv
// Multi-channel PID gain/setpoint register bank. Decodes the bus address
// into channel and register index, routes writes to the channel blocks,
// muxes and registers read data, and tracks a sticky access-error flag.
// Ports:
//   clk_in, reset        clock, synchronous active-high reset
//   bus                  register bus (slave modport)
//   update_tick          per-channel commit strobe
//   p_o/i_o/d_o/sp_o     active sets, channel c at [c*DATA_W +: DATA_W]
//   ch_enable            per-channel CTRL enable
//   commit_done          per-channel commit pulse
//   pid_o_i, pwm_o_i     per-channel status inputs
//   err, err_clr         sticky access error and its clear
module pid_regbank
    import pid_regbank_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                     clk_in,
    input  logic                     reset,
    pid_regbank_if.slave             bus,
    input  logic [NUM_CH-1:0]        update_tick,
    output logic [NUM_CH*DATA_W-1:0] p_o,
    output logic [NUM_CH*DATA_W-1:0] i_o,
    output logic [NUM_CH*DATA_W-1:0] d_o,
    output logic [NUM_CH*DATA_W-1:0] sp_o,
    output logic [NUM_CH-1:0]        ch_enable,
    output logic [NUM_CH-1:0]        commit_done,
    input  logic [NUM_CH*DATA_W-1:0] pid_o_i,
    input  logic [NUM_CH*DATA_W-1:0] pwm_o_i,
    output logic                     err,
    input  logic                     err_clr
);

    logic [CH_W-1:0]   wr_ch;
    logic [IDX_W-1:0]  wr_idx;
    logic [CH_W-1:0]   rd_ch;
    logic [IDX_W-1:0]  rd_idx;
    logic              wr_hi_zero_c;
    logic              rd_hi_zero_c;
    logic              wr_ok_c;
    logic              rd_ok_c;
    logic              wr_bad_c;
    logic              rd_bad_c;
    logic [DATA_W-1:0] chan_rd_c [NUM_CH];
    logic [DATA_W-1:0] rd_word_c;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              err_q;

    assign wr_ch  = bus.wr_addr[FIELD_W-1 -: CH_W];
    assign wr_idx = bus.wr_addr[IDX_W-1:0];
    assign rd_ch  = bus.rd_addr[FIELD_W-1 -: CH_W];
    assign rd_idx = bus.rd_addr[IDX_W-1:0];

    // Any address bits above the channel field must be zero to be valid.
    assign wr_hi_zero_c = (bus.wr_addr >> FIELD_W) == '0;
    assign rd_hi_zero_c = (bus.rd_addr >> FIELD_W) == '0;

    // Address validity: existing channel and a mapped register.
    assign wr_ok_c  = wr_hi_zero_c && (32'(wr_ch) < NUM_CH) && is_wr_reg(wr_idx);
    assign rd_ok_c  = rd_hi_zero_c && (32'(rd_ch) < NUM_CH) && is_rd_reg(rd_idx);
    assign wr_bad_c = bus.wr_en && !wr_ok_c;
    assign rd_bad_c = bus.rd_en && !rd_ok_c;

    // Channel instances; writes reach only the addressed channel.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        pid_chan_regs #(
            .DATA_W (DATA_W)
        ) u_chan (
            .clk_in      (clk_in),
            .reset       (reset),
            .wr_en       (bus.wr_en && wr_ok_c && (wr_ch == CH_W'(c))),
            .wr_idx      (wr_idx),
            .wr_data     (bus.wr_data),
            .update_tick (update_tick[c]),
            .pid_i       (pid_o_i[c*DATA_W +: DATA_W]),
            .pwm_i       (pwm_o_i[c*DATA_W +: DATA_W]),
            .rd_idx      (rd_idx),
            .rd_word_c   (chan_rd_c[c]),
            .p_o         (p_o[c*DATA_W +: DATA_W]),
            .i_o         (i_o[c*DATA_W +: DATA_W]),
            .d_o         (d_o[c*DATA_W +: DATA_W]),
            .sp_o        (sp_o[c*DATA_W +: DATA_W]),
            .ch_enable   (ch_enable[c]),
            .commit_done (commit_done[c])
        );
    end

    // Channel select for reads.
    always_comb begin
        rd_word_c = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (rd_ch == CH_W'(c)) begin
                rd_word_c = chan_rd_c[c];
            end
        end
    end

    // Read data register (holds when idle) and sticky error flag; a new
    // error wins over a same-cycle clear.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_q <= rd_ok_c ? rd_word_c : '0;
            end
            if (wr_bad_c || rd_bad_c) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign err          = err_q;

endmodule

// File: tb/tb_pid_regbank.sv
// Self-checking bench for pid_regbank (DATA_W=16, NUM_CH=2): directed
// scenarios followed by randomized bus/tick traffic, all compared every
// cycle against a register-map level reference model.
module tb_pid_regbank;

    localparam int DW = 16;
    localparam int NC = 2;
    localparam int AW = 8;

    logic              clk_in = 1'b0;
    logic              reset;
    logic [NC-1:0]     update_tick;
    logic [NC*DW-1:0]  p_o, i_o, d_o, sp_o;
    logic [NC-1:0]     ch_enable;
    logic [NC-1:0]     commit_done;
    logic [NC*DW-1:0]  pid_o_i, pwm_o_i;
    logic              err;
    logic              err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    pid_regbank_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    pid_regbank #(.DATA_W(DW), .NUM_CH(NC), .ADDR_W(AW)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .bus         (bus_if.slave),
        .update_tick (update_tick),
        .p_o         (p_o),
        .i_o         (i_o),
        .d_o         (d_o),
        .sp_o        (sp_o),
        .ch_enable   (ch_enable),
        .commit_done (commit_done),
        .pid_o_i     (pid_o_i),
        .pwm_o_i     (pwm_o_i),
        .err         (err),
        .err_clr     (err_clr)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: shadow/active sets as [channel][P,I,D,SP].
    logic [DW-1:0] m_shadow [NC][4];
    logic [DW-1:0] m_active [NC][4];
    logic [DW-1:0] m_pid    [NC];
    logic [DW-1:0] m_pwm    [NC];
    logic          m_en     [NC];
    logic          m_pend   [NC];
    logic          m_done   [NC];
    logic          m_err;
    logic [DW-1:0] m_rd_data;
    logic          m_rd_valid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs presented to it.
    task automatic model_step();
        int rch, rix, wch, wix;
        logic rok, wok, cm;
        logic [DW-1:0] rv;
        if (reset) begin
            for (int c = 0; c < NC; c++) begin
                for (int k = 0; k < 4; k++) begin
                    m_shadow[c][k] = '0;
                    m_active[c][k] = '0;
                end
                m_pid[c] = '0; m_pwm[c] = '0;
                m_en[c] = 1'b0; m_pend[c] = 1'b0; m_done[c] = 1'b0;
            end
            m_err = 1'b0; m_rd_data = '0; m_rd_valid = 1'b0;
            return;
        end
        rch = int'(bus_if.rd_addr[7:4]);
        rix = int'(bus_if.rd_addr[3:0]);
        wch = int'(bus_if.wr_addr[7:4]);
        wix = int'(bus_if.wr_addr[3:0]);
        rok = (rch < NC) && (rix <= 4 || rix >= 14);
        wok = (wch < NC) && (wix <= 4);
        // Reads observe state from before this edge.
        rv = '0;
        if (rok) begin
            if (rix < 4)        rv = m_shadow[rch][rix];
            else if (rix == 4)  rv = {14'd0, m_pend[rch], m_en[rch]};
            else if (rix == 14) rv = m_pid[rch];
            else                rv = m_pwm[rch];
        end
        m_rd_valid = bus_if.rd_en;
        if (bus_if.rd_en) m_rd_data = rv;
        if ((bus_if.wr_en && !wok) || (bus_if.rd_en && !rok)) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        // Commit takes the pre-write shadow set.
        for (int c = 0; c < NC; c++) begin
            cm = m_pend[c] && update_tick[c];
            m_done[c] = cm;
            if (cm) begin
                for (int k = 0; k < 4; k++) m_active[c][k] = m_shadow[c][k];
                m_pend[c] = 1'b0;
            end
        end
        if (bus_if.wr_en && wok) begin
            if (wix < 4) m_shadow[wch][wix] = bus_if.wr_data;
            else begin
                m_en[wch] = bus_if.wr_data[0];
                if (bus_if.wr_data[1]) m_pend[wch] = 1'b1;
            end
        end
        for (int c = 0; c < NC; c++) begin
            m_pid[c] = pid_o_i[c*DW +: DW];
            m_pwm[c] = pwm_o_i[c*DW +: DW];
        end
    endtask

    task automatic check_all();
        chk("rd_valid", 64'(bus_if.rd_valid), 64'(m_rd_valid));
        chk("rd_data", 64'(bus_if.rd_data), 64'(m_rd_data));
        chk("p_o", 64'(p_o), 64'({m_active[1][0], m_active[0][0]}));
        chk("i_o", 64'(i_o), 64'({m_active[1][1], m_active[0][1]}));
        chk("d_o", 64'(d_o), 64'({m_active[1][2], m_active[0][2]}));
        chk("sp_o", 64'(sp_o), 64'({m_active[1][3], m_active[0][3]}));
        chk("ch_enable", 64'(ch_enable), 64'({m_en[1], m_en[0]}));
        chk("commit_done", 64'(commit_done), 64'({m_done[1], m_done[0]}));
        chk("err", 64'(err), 64'(m_err));
    endtask

    task automatic step();
        @(posedge clk_in);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        bus_if.wr_en = 1'b0; bus_if.rd_en = 1'b0;
        update_tick = '0; err_clr = 1'b0; reset = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        bus_if.wr_en = 1'b1; bus_if.wr_addr = a; bus_if.wr_data = d;
        step();
        bus_if.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        bus_if.rd_en = 1'b1; bus_if.rd_addr = a;
        step();
        bus_if.rd_en = 1'b0;
    endtask

    function automatic logic [7:0] rand_addr();
        logic [3:0] ch, ix;
        ch = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15));
        ix = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 15));
        return {ch, ix};
    endfunction

    initial begin
        idle_inputs();
        bus_if.wr_addr = '0; bus_if.wr_data = '0; bus_if.rd_addr = '0;
        pid_o_i = '0; pwm_o_i = '0;

        // Reset state.
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        chk("reset_p_o", 64'(p_o), 64'd0);
        chk("reset_err", 64'(err), 64'd0);

        // Shadow write, readback, active unchanged.
        wr(8'h00, 16'h0123);
        rd(8'h00);
        chk("rd_p_ch0", 64'(bus_if.rd_data), 64'h0123);
        chk("p_o_ch0_unchanged", 64'(p_o[15:0]), 64'h0);
        step();
        chk("rd_data_hold", 64'(bus_if.rd_data), 64'h0123);
        chk("rd_valid_drop", 64'(bus_if.rd_valid), 64'h0);

        // Commit on ch1 a few cycles after the request.
        wr(8'h10, 16'h0AAA);
        wr(8'h14, 16'h0002);
        step(); step();
        update_tick = 2'b10;
        step();
        update_tick = '0;
        chk("commit_p_ch1", 64'(p_o[31:16]), 64'h0AAA);
        chk("commit_done_pulse", 64'(commit_done), 64'h2);
        step();
        chk("commit_done_single", 64'(commit_done), 64'h0);
        rd(8'h14);
        chk("ctrl_after_commit", 64'(bus_if.rd_data), 64'h0);

        // Same-cycle shadow write and commit.
        wr(8'h00, 16'h0011);
        wr(8'h04, 16'h0002);
        bus_if.wr_en = 1'b1; bus_if.wr_addr = 8'h00; bus_if.wr_data = 16'h0055;
        update_tick = 2'b01;
        step();
        bus_if.wr_en = 1'b0; update_tick = '0;
        chk("commit_old_shadow", 64'(p_o[15:0]), 64'h0011);
        rd(8'h00);
        chk("new_shadow_kept", 64'(bus_if.rd_data), 64'h0055);

        // CTRL commit request on a tick cycle only sets pending.
        bus_if.wr_en = 1'b1; bus_if.wr_addr = 8'h04; bus_if.wr_data = 16'h0003;
        update_tick = 2'b01;
        step();
        bus_if.wr_en = 1'b0; update_tick = '0;
        chk("no_same_cycle_commit", 64'(commit_done), 64'h0);
        rd(8'h04);
        chk("ctrl_pending_en", 64'(bus_if.rd_data), 64'h3);

        // Illegal writes set err, clear works.
        wr(8'h0E, 16'hFFFF);
        chk("err_ro_write", 64'(err), 64'h1);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("err_cleared", 64'(err), 64'h0);
        wr(8'h35, 16'hFFFF);
        chk("err_bad_channel", 64'(err), 64'h1);
        bus_if.wr_en = 1'b1; bus_if.wr_addr = 8'h07; err_clr = 1'b1;
        step();
        bus_if.wr_en = 1'b0; err_clr = 1'b0;
        chk("err_set_beats_clr", 64'(err), 64'h1);
        err_clr = 1'b1; step(); err_clr = 1'b0;

        // Status sampling latency.
        pid_o_i = {16'h0000, 16'hBEEF};
        step();
        rd(8'h0E);
        chk("pid_status_read", 64'(bus_if.rd_data), 64'hBEEF);

        // Reset discards a pending commit.
        wr(8'h14, 16'h0003);
        reset = 1'b1; bus_if.wr_en = 1'b1; bus_if.wr_addr = 8'h10; bus_if.wr_data = 16'h7777;
        step();
        reset = 1'b0; bus_if.wr_en = 1'b0;
        update_tick = 2'b11;
        step();
        update_tick = '0;
        chk("no_commit_after_reset", 64'(commit_done), 64'h0);
        chk("p_o_zero_after_reset", 64'(p_o), 64'h0);
        chk("en_zero_after_reset", 64'(ch_enable), 64'h0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            reset          = ($urandom_range(0, 79) == 0);
            bus_if.wr_en   = 1'($urandom_range(0, 1));
            bus_if.wr_addr = rand_addr();
            bus_if.wr_data = 16'($urandom);
            bus_if.rd_en   = 1'($urandom_range(0, 1));
            bus_if.rd_addr = ($urandom_range(0, 3) == 0) ? bus_if.wr_addr : rand_addr();
            update_tick    = 2'($urandom_range(0, 3));
            err_clr        = ($urandom_range(0, 7) == 0);
            pid_o_i        = {16'($urandom), 16'($urandom)};
            pwm_o_i        = {16'($urandom), 16'($urandom)};
            step();
        end

        idle_inputs();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
